// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback / register-file stage.
package wb_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  // func3 load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [REG_IDX_W-1:0] ECALL_IDX = REG_IDX_W'(17);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the byte/half lane of a loaded word and sign- or zero-extends it.
module load_extend
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (lane)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    value = word;
    case (func3)
      F3_LB:   value = {{24{w_byte[7]}}, w_byte};
      F3_LH:   value = {{16{w_half[15]}}, w_half};
      F3_LW:   value = word;
      F3_LBU:  value = {24'h000000, w_byte};
      F3_LHU:  value = {16'h0000, w_half};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage with 32x32 register file, write-through reads, retire
// counter and an ecall-driven RUN/HALT state machine.
module wb_regfile
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      dm_out_reg,
  input  logic [XLEN-1:0]      alu_out_reg,
  input  logic [REG_IDX_W-1:0] rd_index_reg,
  input  logic                 wb_sel_reg,
  input  logic                 wb_en_reg,
  input  logic [2:0]           func3_reg,
  input  logic                 ecall_sig_reg,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic [XLEN-1:0]      wb_data,
  output logic                 halt,
  output logic [XLEN-1:0]      ecall_code,
  output logic [XLEN-1:0]      retire_cnt
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] r_retire_cnt;
  logic [XLEN-1:0] r_ecall_code;
  logic            r_halt;
  state_t          r_state;

  logic [XLEN-1:0] w_load_val;
  logic            w_commit;
  logic [XLEN-1:0] w_x17;

  load_extend u_load_extend (
    .word  (dm_out_reg),
    .lane  (alu_out_reg[1:0]),
    .func3 (func3_reg),
    .value (w_load_val)
  );

  assign wb_data  = wb_sel_reg ? w_load_val : alu_out_reg;
  assign w_commit = wb_en_reg && (rd_index_reg != '0) && (r_state == RUN);

  // Reads see a write committing on the coming edge.
  always_comb begin
    rs1_data = r_regs[rs1_index];
    rs2_data = r_regs[rs2_index];
    w_x17    = r_regs[ECALL_IDX];
    if (w_commit && (rs1_index == rd_index_reg)) rs1_data = wb_data;
    if (w_commit && (rs2_index == rd_index_reg)) rs2_data = wb_data;
    if (w_commit && (rd_index_reg == ECALL_IDX)) w_x17    = wb_data;
    if (rs1_index == '0) rs1_data = '0;
    if (rs2_index == '0) rs2_data = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
      r_retire_cnt <= '0;
    end else if (w_commit) begin
      r_regs[rd_index_reg] <= wb_data;
      r_retire_cnt         <= r_retire_cnt + XLEN'(1);
    end
  end

  // HALT is sticky; ecall_code captures x17 including a same-edge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= RUN;
      r_halt       <= 1'b0;
      r_ecall_code <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (ecall_sig_reg) begin
            r_state      <= HALT;
            r_halt       <= 1'b1;
            r_ecall_code <= w_x17;
          end
        end
        default: begin
          r_state <= HALT;
          r_halt  <= 1'b1;
        end
      endcase
    end
  end

  assign halt       = r_halt;
  assign ecall_code = r_ecall_code;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: load-extension vector table plus
// scoreboarded sequences for commit, bypass, x0, ecall, reset and wrap.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] dm_out_reg;
  logic [31:0] alu_out_reg;
  logic [4:0]  rd_index_reg;
  logic        wb_sel_reg;
  logic        wb_en_reg;
  logic [2:0]  func3_reg;
  logic        ecall_sig_reg;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        halt;
  logic [31:0] ecall_code;
  logic [31:0] retire_cnt;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .dm_out_reg    (dm_out_reg),
    .alu_out_reg   (alu_out_reg),
    .rd_index_reg  (rd_index_reg),
    .wb_sel_reg    (wb_sel_reg),
    .wb_en_reg     (wb_en_reg),
    .func3_reg     (func3_reg),
    .ecall_sig_reg (ecall_sig_reg),
    .rs1_index     (rs1_index),
    .rs2_index     (rs2_index),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_data       (wb_data),
    .halt          (halt),
    .ecall_code    (ecall_code),
    .retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] dm;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic        sel;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs [10];
  sb_t  sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    sb_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_underflow: got 0x%08h with no expectation", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h want 0x%08h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic drive(input logic en, input logic sel, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [2:0] f3, input logic ec);
    wb_en_reg     = en;
    wb_sel_reg    = sel;
    rd_index_reg  = rd;
    alu_out_reg   = alu;
    dm_out_reg    = dm;
    func3_reg     = f3;
    ecall_sig_reg = ec;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"lb_lane3",   32'h80FF7F01, 32'h3, 3'b000, 1'b1, 32'hFFFFFF80};
    vecs[1] = '{"lbu_lane3",  32'h80FF7F01, 32'h3, 3'b100, 1'b1, 32'h00000080};
    vecs[2] = '{"lh_lane2",   32'h80FF7F01, 32'h2, 3'b001, 1'b1, 32'hFFFF80FF};
    vecs[3] = '{"lhu_lane0",  32'h80FF7F01, 32'h0, 3'b101, 1'b1, 32'h00007F01};
    vecs[4] = '{"lb_lane1",   32'h80FF7F01, 32'h1, 3'b000, 1'b1, 32'h0000007F};
    vecs[5] = '{"lb_lane2",   32'h80FF7F01, 32'h2, 3'b000, 1'b1, 32'hFFFFFFFF};
    vecs[6] = '{"lhu_lane2",  32'h80FF7F01, 32'h2, 3'b101, 1'b1, 32'h000080FF};
    vecs[7] = '{"lw",         32'h80FF7F01, 32'h1, 3'b010, 1'b1, 32'h80FF7F01};
    vecs[8] = '{"f3_011_raw", 32'h80FF7F01, 32'h3, 3'b011, 1'b1, 32'h80FF7F01};
    vecs[9] = '{"alu_path",   32'h80FF7F01, 32'hDEADBEEF, 3'b000, 1'b0, 32'hDEADBEEF};

    rst = 1'b0;
    rs1_index = 5'd5;
    rs2_index = 5'd17;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    push("rst_halt", 32'h0);  pop_chk({31'h0, halt});
    push("rst_cnt", 32'h0);   pop_chk(retire_cnt);
    push("rst_ecode", 32'h0); pop_chk(ecall_code);
    push("rst_rs1", 32'h0);   pop_chk(rs1_data);
    rst = 1'b1;

    // Load-extension table (no writes)
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b0, vecs[i].sel, 5'd9, vecs[i].alu, vecs[i].dm, vecs[i].f3, 1'b0);
      push(vecs[i].name, vecs[i].exp);
      #1;
      pop_chk(wb_data);
    end
    @(negedge clk);
    push("no_write_cnt", 32'h0); pop_chk(retire_cnt);

    // ALU write to x5
    drive(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    rs1_index = 5'd5;
    push("alu_wr_x5", 32'h1234); push("alu_wr_cnt", 32'h1);
    #1; pop_chk(rs1_data); pop_chk(retire_cnt);

    // Write to x0 is discarded
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF, 32'h0, 3'b000, 1'b0);
    rs1_index = 5'd0;
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    push("x0_read", 32'h0); push("x0_cnt", 32'h1);
    #1; pop_chk(rs1_data); pop_chk(retire_cnt);

    // Same-cycle bypass on rs2
    drive(1'b1, 1'b0, 5'd7, 32'h77, 32'h0, 3'b000, 1'b0);
    rs2_index = 5'd7;
    rs1_index = 5'd5;
    push("bypass_rs2", 32'h77); push("bypass_rs1_other", 32'h1234);
    #1; pop_chk(rs2_data); pop_chk(rs1_data);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    push("x7_after", 32'h77); push("x7_cnt", 32'h2);
    #1; pop_chk(rs2_data); pop_chk(retire_cnt);

    // Load-path commit to x8
    drive(1'b1, 1'b1, 5'd8, 32'h3, 32'h80FF7F01, 3'b000, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    rs1_index = 5'd8;
    push("load_wr_x8", 32'hFFFFFF80); push("load_wr_cnt", 32'h3);
    #1; pop_chk(rs1_data); pop_chk(retire_cnt);

    // Ecall with simultaneous x17 write
    drive(1'b1, 1'b0, 5'd17, 32'h5D, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd17, 32'h2A, 32'h0, 3'b000, 1'b1);
    rs2_index = 5'd17;
    push("pre_ecall_halt", 32'h0); push("pre_ecall_x17_byp", 32'h2A);
    #1; pop_chk({31'h0, halt}); pop_chk(rs2_data);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    push("ecall_halt", 32'h1); push("ecall_code", 32'h2A);
    push("ecall_x17", 32'h2A); push("ecall_cnt", 32'h5);
    #1; pop_chk({31'h0, halt}); pop_chk(ecall_code);
    pop_chk(rs2_data); pop_chk(retire_cnt);

    // Writes ignored while halted, no bypass either
    drive(1'b1, 1'b0, 5'd3, 32'h33, 32'h0, 3'b000, 1'b1);
    rs1_index = 5'd3;
    push("halt_no_bypass", 32'h0);
    #1; pop_chk(rs1_data);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    push("halt_x3", 32'h0); push("halt_cnt", 32'h5);
    push("halt_sticky", 32'h1); push("halt_ecode_hold", 32'h2A);
    #1; pop_chk(rs1_data); pop_chk(retire_cnt);
    pop_chk({31'h0, halt}); pop_chk(ecall_code);

    // Asynchronous reset mid-cycle while halted
    @(posedge clk);
    #2 rst = 1'b0;
    rs1_index = 5'd5;
    rs2_index = 5'd17;
    #1;
    push("arst_halt", 32'h0); push("arst_cnt", 32'h0);
    push("arst_ecode", 32'h0); push("arst_x5", 32'h0); push("arst_x17", 32'h0);
    pop_chk({31'h0, halt}); pop_chk(retire_cnt);
    pop_chk(ecall_code); pop_chk(rs1_data); pop_chk(rs2_data);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 5'd1, 32'h9, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    rs1_index = 5'd1;
    push("post_rst_x1", 32'h9); push("post_rst_cnt", 32'h1);
    #1; pop_chk(rs1_data); pop_chk(retire_cnt);

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.r_retire_cnt = 32'hFFFFFFFF;
    #1 release dut.r_retire_cnt;
    drive(1'b1, 1'b0, 5'd2, 32'h2, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    rs1_index = 5'd2;
    push("wrap_cnt", 32'h0); push("wrap_x2", 32'h2);
    #1; pop_chk(retire_cnt); pop_chk(rs1_data);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
